// File: rtl/regbank_pkg.sv
// Shared defaults and state encoding for the register-bank write-port controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regbank_pkg;

  localparam int REGBANK_NREG = 8;
  localparam int REGBANK_AW   = 3;
  localparam int REGBANK_DW   = 8;

  // IDLE arbitrates writers; CLEAR walks the per-register reset lines
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/regbank_arb_if.sv
// Bundle of writer handshakes, clear control and bank-side strobes.
// Latency: n/a (wiring only).
// Backpressure: req*_ready is driven by the controller (slave modport).
interface regbank_arb_if #(
  parameter int NREG = regbank_pkg::REGBANK_NREG,
  parameter int AW   = regbank_pkg::REGBANK_AW,
  parameter int DW   = regbank_pkg::REGBANK_DW
);
  logic            req0_valid;
  logic [AW-1:0]   req0_addr;
  logic [DW-1:0]   req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [AW-1:0]   req1_addr;
  logic [DW-1:0]   req1_data;
  logic            req1_ready;
  logic            clr_req;
  logic            clr_busy;
  logic [NREG-1:0] reg_we;
  logic [DW-1:0]   reg_d;
  logic [NREG-1:0] reg_rst;

  // Writer / execute-stage side
  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output clr_req,
    input  clr_busy, reg_we, reg_d, reg_rst
  );

  // Controller side
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  clr_req,
    output clr_busy, reg_we, reg_d, reg_rst
  );
endinterface

// File: rtl/regbank_arb_rr_arb2.sv
// rr_arb2: two-way arbiter; round-robin by default, fixed req0 priority with REGBANK_ARB_FIXED_PRIO_EN.
// Latency: grants are combinational from valids; last_grant updates on the transfer edge.
// Backpressure: a grant is only a candidate; the caller qualifies it into ready.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic i_vld0,
  input  logic i_vld1,
  input  logic i_xfer,
  output logic o_gnt0,
  output logic o_gnt1
);
`ifdef REGBANK_ARB_FIXED_PRIO_EN
  // No history: req0 always wins a collision
  logic w_unused;
  assign w_unused = &{1'b0, clk, reset, i_xfer};
  assign o_gnt0   = i_vld0;
  assign o_gnt1   = i_vld1 & ~i_vld0;
`else
  logic r_last_grant;  // 1 = writer 1 won the most recent transfer

  // On a collision, favour whichever writer did not win last time
  assign o_gnt0 = i_vld0 & (~i_vld1 | r_last_grant);
  assign o_gnt1 = i_vld1 & (~i_vld0 | ~r_last_grant);

  // Remember the winner of each completed transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (i_xfer) begin
      r_last_grant <= o_gnt1;
    end
  end
`endif
endmodule

// File: rtl/regbank_arb.sv
// regbank_arb: arbitrates two writers onto one registered bank write port and sequences a bank clear.
// Latency: accepted write appears on reg_we/reg_d one cycle later; clear strobes start one cycle after clr_req.
// Backpressure: ready is withheld during reset, during CLEAR, and in the cycle clr_req is seen.
// Optional macro: REGBANK_ARB_FIXED_PRIO_EN (fixed req0 priority inside rr_arb2).
module regbank_arb
  import regbank_pkg::*;
#(
  parameter int NREG = REGBANK_NREG,
  parameter int AW   = REGBANK_AW,
  parameter int DW   = REGBANK_DW
) (
  input logic          clk,
  input logic          reset,
  regbank_arb_if.slave bus
);
  localparam logic [NREG-1:0] ONE      = NREG'(1);
  localparam logic [AW-1:0]   LAST_IDX = AW'(NREG - 1);

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_clr_idx, w_clr_idx_nxt;
  logic            r_clr_busy, w_clr_busy_nxt;
  logic [NREG-1:0] r_reg_rst, w_reg_rst_nxt;
  logic [NREG-1:0] r_reg_we, w_reg_we_nxt;
  logic [DW-1:0]   r_reg_d;
  logic            w_gnt0, w_gnt1, w_rdy0, w_rdy1, w_xfer0, w_xfer1, w_idle;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .i_vld0 (bus.req0_valid),
    .i_vld1 (bus.req1_valid),
    .i_xfer (w_xfer0 | w_xfer1),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  // A clear request pre-empts any write offered in the same cycle
  assign w_idle  = (r_state == ST_IDLE);
  assign w_rdy0  = ~reset & w_idle & ~bus.clr_req & w_gnt0;
  assign w_rdy1  = ~reset & w_idle & ~bus.clr_req & w_gnt1;
  assign w_xfer0 = bus.req0_valid & w_rdy0;
  assign w_xfer1 = bus.req1_valid & w_rdy1;

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.clr_busy   = r_clr_busy;
  assign bus.reg_rst    = r_reg_rst;
  assign bus.reg_we     = r_reg_we;
  assign bus.reg_d      = r_reg_d;

  // Next state plus clear-walk strobes; clr_req while already clearing is ignored
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_idx_nxt  = r_clr_idx;
    w_clr_busy_nxt = r_clr_busy;
    w_reg_rst_nxt  = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.clr_req) begin
          w_state_nxt    = ST_CLEAR;
          w_clr_idx_nxt  = '0;
          w_clr_busy_nxt = 1'b1;
          w_reg_rst_nxt  = ONE;
        end
      end
      ST_CLEAR: begin
        if (r_clr_idx == LAST_IDX) begin
          w_state_nxt    = ST_IDLE;
          w_clr_idx_nxt  = '0;
          w_clr_busy_nxt = 1'b0;
        end else begin
          w_clr_idx_nxt  = r_clr_idx + AW'(1);
          w_reg_rst_nxt  = ONE << w_clr_idx_nxt;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_clr_idx_nxt  = '0;
        w_clr_busy_nxt = 1'b0;
      end
    endcase
  end

  // Grants are exclusive, so at most one writer feeds the one-hot enable
  always_comb begin
    w_reg_we_nxt = '0;
    if (w_xfer0) begin
      w_reg_we_nxt = ONE << bus.req0_addr;
    end else if (w_xfer1) begin
      w_reg_we_nxt = ONE << bus.req1_addr;
    end
  end

  // FSM and clear-walk registers; reset aborts a clear in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_clr_idx  <= '0;
      r_clr_busy <= 1'b0;
      r_reg_rst  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_idx  <= w_clr_idx_nxt;
      r_clr_busy <= w_clr_busy_nxt;
      r_reg_rst  <= w_reg_rst_nxt;
    end
  end

  // Write port: enable pulses for one cycle, data holds between writes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_we <= '0;
      r_reg_d  <= '0;
    end else begin
      r_reg_we <= w_reg_we_nxt;
      if (w_xfer0) begin
        r_reg_d <= bus.req0_data;
      end else if (w_xfer1) begin
        r_reg_d <= bus.req1_data;
      end
    end
  end
endmodule

// File: tb/tb_regbank_arb.sv
// Bench for regbank_arb: directed scenarios followed by random traffic, scored against a queue-based model.
// Latency: n/a.
// Backpressure: writers hold valid/addr/data until accepted.
module tb_regbank_arb;
  localparam int NREG = 8;

  typedef struct {
    int         cyc;
    logic [7:0] we;
    logic [7:0] d;
  } wexp_t;

  typedef struct {
    int         cyc;
    logic [7:0] rst;
  } rexp_t;

  logic clk;
  logic reset;
  regbank_arb_if #(.NREG(8), .AW(3), .DW(8)) bus ();

  regbank_arb #(.NREG(8), .AW(3), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  bit    mon_on = 1'b0;
  wexp_t wq[$];
  rexp_t rq[$];
  logic [7:0] exp_d = 8'h00;
  int    d_zero_cyc = -1;

  // model state
  int         busy_left = 0;  // clear cycles still to be shown from next cycle on
  int         last = 1;       // writer that won the most recent transfer
  bit         p_v[2];
  logic [2:0] p_a[2];
  logic [7:0] p_d[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive, check handshake outputs, advance the model
  task automatic step(input bit rst_i, input bit clr_i);
    bit g0, g1, idle, e0, e1;
    @(posedge clk);
    cyc++;
    #1;
    reset          = rst_i;
    bus.clr_req    = clr_i;
    bus.req0_valid = p_v[0];
    bus.req0_addr  = p_a[0];
    bus.req0_data  = p_d[0];
    bus.req1_valid = p_v[1];
    bus.req1_addr  = p_a[1];
    bus.req1_data  = p_d[1];
    #1;
    idle = (busy_left == 0);
`ifdef REGBANK_ARB_FIXED_PRIO_EN
    g0 = p_v[0];
    g1 = p_v[1] && !p_v[0];
`else
    g0 = p_v[0] && (!p_v[1] || last == 1);
    g1 = p_v[1] && (!p_v[0] || last == 0);
`endif
    e0 = !rst_i && idle && !clr_i && g0;
    e1 = !rst_i && idle && !clr_i && g1;
    chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
    chk("clr_busy", 32'(bus.clr_busy), 32'(busy_left > 0));
    for (int k = 0; k < 2; k++) begin
      if ((k == 0 ? e0 : e1) && p_v[k]) begin
        wq.push_back('{cyc: cyc + 1, we: 8'(1) << p_a[k], d: p_d[k]});
        last   = k;
        p_v[k] = 1'b0;
      end
    end
    if (rst_i) begin
      busy_left  = 0;
      last       = 1;
      d_zero_cyc = cyc + 1;
      while (rq.size() > 0 && rq[$].cyc > cyc) void'(rq.pop_back());
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (clr_i) begin
      busy_left = NREG;
      for (int k = 0; k < NREG; k++) rq.push_back('{cyc: cyc + 1 + k, rst: 8'(1) << k});
    end
  endtask

  // Monitor: pop an expectation whenever a strobe appears, flag any that never did
  always @(negedge clk) begin
    if (mon_on) begin
      if (cyc == d_zero_cyc) exp_d = 8'h00;
      if (bus.reg_we != 8'h00) begin
        if (wq.size() == 0) begin
          chk("reg_we_unexpected", 32'(bus.reg_we), 32'h0);
        end else begin
          chk("we_cycle", 32'(cyc), 32'(wq[0].cyc));
          chk("reg_we", 32'(bus.reg_we), 32'(wq[0].we));
          chk("reg_d", 32'(bus.reg_d), 32'(wq[0].d));
          exp_d = wq[0].d;
          void'(wq.pop_front());
        end
      end else begin
        if (wq.size() > 0 && wq[0].cyc <= cyc) begin
          chk("reg_we_missing", 32'(bus.reg_we), 32'(wq[0].we));
          void'(wq.pop_front());
        end
        chk("reg_d_hold", 32'(bus.reg_d), 32'(exp_d));
      end
      if (bus.reg_rst != 8'h00) begin
        if (rq.size() == 0) begin
          chk("reg_rst_unexpected", 32'(bus.reg_rst), 32'h0);
        end else begin
          chk("rst_cycle", 32'(cyc), 32'(rq[0].cyc));
          chk("reg_rst", 32'(bus.reg_rst), 32'(rq[0].rst));
          void'(rq.pop_front());
        end
      end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        chk("reg_rst_missing", 32'(bus.reg_rst), 32'(rq[0].rst));
        void'(rq.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.clr_req = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    for (int k = 0; k < 2; k++) begin
      p_v[k] = 1'b0; p_a[k] = '0; p_d[k] = '0;
    end
    step(1, 0);
    mon_on = 1'b1;
    step(1, 0);
    // reset state observed directly
    chk("rst_reg_we", 32'(bus.reg_we), 32'h0);
    chk("rst_reg_rst", 32'(bus.reg_rst), 32'h0);
    chk("rst_reg_d", 32'(bus.reg_d), 32'h0);

    // single write
    p_v[0] = 1; p_a[0] = 3'd3; p_d[0] = 8'hAA;
    step(0, 0); step(0, 0); step(0, 0);

    // both writers contending for four cycles
    for (int i = 0; i < 4; i++) begin
      p_v[0] = 1; p_a[0] = 3'd1; p_d[0] = 8'h11;
      p_v[1] = 1; p_a[1] = 3'd2; p_d[1] = 8'h22;
      step(0, 0);
    end
    p_v[0] = 0; p_v[1] = 0;
    step(0, 0); step(0, 0);

    // clear pre-empts a writer offered in the same cycle
    p_v[1] = 1; p_a[1] = 3'd5; p_d[1] = 8'h33;
    step(0, 1);
    for (int i = 0; i < 12; i++) step(0, 0);

    // second clear request mid-clear is ignored
    step(0, 1); step(0, 0); step(0, 0); step(0, 1);
    for (int i = 0; i < 10; i++) step(0, 0);

    // reset aborts a clear; the next clear restarts at index 0
    step(0, 1); step(0, 0); step(0, 0); step(0, 0);
    step(1, 0); step(0, 0);
    step(0, 1);
    for (int i = 0; i < 10; i++) step(0, 0);

    // write accepted, then clear requested the next cycle
    p_v[0] = 1; p_a[0] = 3'd6; p_d[0] = 8'h5A;
    step(0, 0); step(0, 1);
    for (int i = 0; i < 10; i++) step(0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!p_v[k] && $urandom_range(0, 2) == 0) begin
          p_v[k] = 1'b1;
          p_a[k] = 3'($urandom_range(0, 7));
          p_d[k] = 8'($urandom);
        end
      end
      step($urandom_range(0, 399) == 0, $urandom_range(0, 24) == 0);
    end

    // drain
    for (int i = 0; i < 12; i++) step(0, 0);
    p_v[0] = 0; p_v[1] = 0;
    for (int i = 0; i < 12; i++) step(0, 0);
    chk("wq_drained", 32'(wq.size()), 32'h0);
    chk("rq_drained", 32'(rq.size()), 32'h0);
    mon_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
